mc_control_fsm: RTL
===================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning 1 = memory states wait for mem_ready, 0 = mem_ready internally forced to 1.
REQ-002 Parameter MEM_TIMEOUT, default 15, meaning max wait cycles before timeout trap; 0 disables timeout.
REQ-003 Parameter WAIT_W, default 4, meaning wait-counter width; MEM_TIMEOUT SHALL fit in WAIT_W bits.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 op  input  7  opcode, instruction register bits [6:0].
REQ-007 funct3  input  3  instruction register bits [14:12].
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-010 PCSource, ALUOp, ALUSrcB  output  2 each  datapath selects.
REQ-011 BranchNe  output  1  invert zero for branch (bne).
REQ-012 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-013 trap  output  1  sticky fault flag; trap_cause  output  2  (00 none, 01 illegal opcode, 10 memory timeout).
REQ-014 state  output  4  current state encoding, debug.

Function
REQ-015 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, TRAP.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite asserted only in the cycle mem_ready=1; advance to DECODE on that cycle.
REQ-017 DECODE (1 cycle): ALUSrcA=0, ALUSrcB=10, ALUOp=00. Next state by op: 0000011 -> MEM_ADDR, 0100011 -> MEM_ADDR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, any other -> TRAP with cause 01.
REQ-018 MEM_ADDR (1 cycle): ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM_READ if op=0000011, else MEM_WRITE.
REQ-019 MEM_READ: MemRead=1, IorD=1; on mem_ready -> MEM_WB.
REQ-020 MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1; next FETCH.
REQ-021 MEM_WRITE: MemWrite=1, IorD=1; on mem_ready: instr_done=1, next FETCH.
REQ-022 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11; both -> ALU_WB.
REQ-023 ALU_WB: RegWrite=1, MemtoReg=0, instr_done=1; next FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=(funct3==001), instr_done=1; next FETCH; funct3 other than 000/001 -> TRAP cause 01 with PCWriteCond=0.
REQ-025 All controls not listed for a state SHALL be 0.
REQ-026 Wait states (FETCH, MEM_READ, MEM_WRITE): counter clears on state entry, increments each cycle mem_ready=0, saturates at all-ones.
REQ-027 If MEM_TIMEOUT!=0 and counter equals MEM_TIMEOUT with mem_ready=0, next state TRAP, cause 10; mem_ready=1 in the same cycle wins over timeout.
REQ-028 TRAP: all controls 0, trap=1, trap_cause held; leaves only via reset.
REQ-029 With MEM_HANDSHAKE=0 every wait state lasts exactly one cycle and timeout never fires.
REQ-030 Latencies at zero wait: load 5, store 4, R/I-type 4, branch 3 cycles.

Reset
REQ-031 reset asserted SHALL immediately force state=FETCH, counter=0, trap=0, trap_cause=00.
REQ-032 While reset is high all control outputs and instr_done SHALL be 0; first FETCH cycle follows deassertion.
REQ-033 Reset mid-instruction or in TRAP SHALL abandon it with no further write strobes.

Structure
REQ-034 State encoding, opcode constants, ALUOp/ALUSrcB/PCSource codes and trap causes SHALL live in shared package mc_ctrl_pkg.
REQ-035 Wait counter/timeout SHALL be sub-module mem_wait_timer (inputs clear, ready; output expired).

Verification
REQ-036 add (op 0110011), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; RegWrite=1 only in ALU_WB; instr_done pulse cycle 4.
REQ-037 ld, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, MEM_WB then FETCH, total 8 cycles.
REQ-038 bne (funct3 001) -> BRANCH with PCWriteCond=1, PCSource=01, BranchNe=1.
REQ-039 op 1111111 -> TRAP after DECODE, trap=1, trap_cause=01, outputs 0 until reset.
REQ-040 MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP on cycle 16, trap_cause=10; IRWrite never asserted.
REQ-041 reset pulsed during MEM_WRITE -> MemWrite drops same cycle, FETCH after release, trap=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, opcodes,
// datapath select codes and trap causes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      EXEC_I    = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      TRAP      = 4'd10
   } stateT;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_IMM   = 2'b11
   } aluOpT;

   typedef enum logic [1:0] {
      SRCB_REG  = 2'b00,
      SRCB_FOUR = 2'b01,
      SRCB_IMM  = 2'b10
   } srcBT;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01
   } pcSrcT;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } trapCauseT;

   // States that stall on the memory handshake and run the wait timer.
   function automatic logic isWaitState(stateT s);
      return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
   endfunction

   function automatic logic isLegalBranch(logic [2:0] f3);
      return (f3 == F3_BEQ) || (f3 == F3_BNE);
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction/memory inputs and datapath control outputs of the controller.
interface mc_control_fsm_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       mem_ready;

   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] PCSource;
   logic [1:0] ALUOp;
   logic [1:0] ALUSrcB;
   logic       BranchNe;
   logic       instr_done;
   logic       trap;
   logic [1:0] trap_cause;
   logic [3:0] state;

   modport master (
      input  op, funct3, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegWrite, ALUSrcA, PCSource, ALUOp, ALUSrcB, BranchNe, instr_done,
             trap, trap_cause, state
   );

   modport slave (
      output op, funct3, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegWrite, ALUSrcA, PCSource, ALUOp, ALUSrcB, BranchNe, instr_done,
             trap, trap_cause, state
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory wait state and flags when the configured
// timeout is reached while memory is still not ready.
module mem_wait_timer #(
   parameter int WAIT_W      = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic ready,
   output logic expired
);

   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

   logic [WAIT_W-1:0] waitCnt;

   // Saturating so a disabled timeout never wraps back into a match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         waitCnt <= '0;
      end else if (clear) begin
         waitCnt <= '0;
      end else if (!ready && (waitCnt != '1)) begin
         waitCnt <= waitCnt + 1'b1;
      end
   end

   assign expired = (MEM_TIMEOUT != 0) && !ready && (waitCnt == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-style control FSM: sequences fetch, decode, memory, ALU and
// branch steps, with memory handshake, wait timeout and a sticky trap state.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int MEM_TIMEOUT   = 15,
   parameter int WAIT_W        = 4
) (
   input  logic              clk,
   input  logic              reset,
   mc_control_fsm_if.master  bus
);

   if (MEM_TIMEOUT >= (1 << WAIT_W)) begin : gTimeoutFit
      $error("MEM_TIMEOUT does not fit in WAIT_W bits");
   end

   stateT     state, nextState;
   trapCauseT trapCause, nextCause;

   logic      ready;
   logic      expired;
   logic      timerClear;

   logic      pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic      memtoReg, regWrite, aluSrcA, branchNe, instrDone;
   aluOpT     aluOp;
   srcBT      aluSrcB;
   pcSrcT     pcSource;

   assign ready = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

   // Counter restarts on every state change, so each wait state sees 0 on entry.
   assign timerClear = (nextState != state) || !isWaitState(state);

   mem_wait_timer #(
      .WAIT_W      (WAIT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) uWaitTimer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timerClear),
      .ready   (ready),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         trapCause <= CAUSE_NONE;
      end else begin
         state     <= nextState;
         trapCause <= nextCause;
      end
   end

   always_comb begin
      nextState   = state;
      nextCause   = trapCause;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memtoReg    = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      branchNe    = 1'b0;
      instrDone   = 1'b0;
      aluOp       = ALUOP_ADD;
      aluSrcB     = SRCB_REG;
      pcSource    = PCSRC_ALU;

      case (state)
         FETCH: begin
            memRead = 1'b1;
            aluSrcB = SRCB_FOUR;
            if (ready) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               nextState = DECODE;
            end else if (expired) begin
               nextState = TRAP;
               nextCause = CAUSE_TIMEOUT;
            end
         end

         DECODE: begin
            aluSrcB = SRCB_IMM;
            case (bus.op)
               OP_LOAD, OP_STORE: nextState = MEM_ADDR;
               OP_RTYPE:          nextState = EXEC_R;
               OP_ITYPE:          nextState = EXEC_I;
               OP_BRANCH:         nextState = BRANCH;
               default: begin
                  nextState = TRAP;
                  nextCause = CAUSE_ILLEGAL;
               end
            endcase
         end

         MEM_ADDR: begin
            aluSrcA   = 1'b1;
            aluSrcB   = SRCB_IMM;
            nextState = (bus.op == OP_LOAD) ? MEM_READ : MEM_WRITE;
         end

         MEM_READ: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            if (ready) begin
               nextState = MEM_WB;
            end else if (expired) begin
               nextState = TRAP;
               nextCause = CAUSE_TIMEOUT;
            end
         end

         MEM_WB: begin
            regWrite  = 1'b1;
            memtoReg  = 1'b1;
            instrDone = 1'b1;
            nextState = FETCH;
         end

         MEM_WRITE: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            if (ready) begin
               instrDone = 1'b1;
               nextState = FETCH;
            end else if (expired) begin
               nextState = TRAP;
               nextCause = CAUSE_TIMEOUT;
            end
         end

         EXEC_R: begin
            aluSrcA   = 1'b1;
            aluOp     = ALUOP_FUNCT;
            nextState = ALU_WB;
         end

         EXEC_I: begin
            aluSrcA   = 1'b1;
            aluSrcB   = SRCB_IMM;
            aluOp     = ALUOP_IMM;
            nextState = ALU_WB;
         end

         ALU_WB: begin
            regWrite  = 1'b1;
            instrDone = 1'b1;
            nextState = FETCH;
         end

         BRANCH: begin
            aluSrcA  = 1'b1;
            aluOp    = ALUOP_SUB;
            pcSource = PCSRC_ALUOUT;
            // Unsupported compare kinds must not touch the PC or retire.
            if (isLegalBranch(bus.funct3)) begin
               pcWriteCond = 1'b1;
               branchNe    = (bus.funct3 == F3_BNE);
               instrDone   = 1'b1;
               nextState   = FETCH;
            end else begin
               nextState = TRAP;
               nextCause = CAUSE_ILLEGAL;
            end
         end

         TRAP: begin
            nextState = TRAP;
         end

         default: begin
            nextState = FETCH;
         end
      endcase
   end

   // Reset is asynchronous, so strobes are masked combinationally as well.
   assign bus.PCWrite     = pcWrite     & ~reset;
   assign bus.PCWriteCond = pcWriteCond & ~reset;
   assign bus.IorD        = iorD        & ~reset;
   assign bus.MemRead     = memRead     & ~reset;
   assign bus.MemWrite    = memWrite    & ~reset;
   assign bus.IRWrite     = irWrite     & ~reset;
   assign bus.MemtoReg    = memtoReg    & ~reset;
   assign bus.RegWrite    = regWrite    & ~reset;
   assign bus.ALUSrcA     = aluSrcA     & ~reset;
   assign bus.BranchNe    = branchNe    & ~reset;
   assign bus.instr_done  = instrDone   & ~reset;
   assign bus.PCSource    = reset ? 2'b00 : pcSource;
   assign bus.ALUOp       = reset ? 2'b00 : aluOp;
   assign bus.ALUSrcB     = reset ? 2'b00 : aluSrcB;
   assign bus.trap        = (state == TRAP) & ~reset;
   assign bus.trap_cause  = trapCause;
   assign bus.state       = state;

endmodule
